// File: rtl/spicart_bridge.sv
// SPI-slave (mode 0, active-high cs) to cartridge-bus bridge: cmd + address + data frames become
// single-clk cart_rd/cart_wr strobes, with burst/fixed addressing, read prefetch and sticky error flags.
module spicart_bridge #(
    parameter int ADDR_W      = 16,
    parameter int DUMMY_BYTES = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              spi_sck,
    input  logic              spi_cs,
    output logic [7:0]        cart_dout,
    input  logic [7:0]        cart_din,
    output logic [ADDR_W-1:0] cart_a,
    output logic              cart_wr,
    output logic              cart_rd,
    input  logic              cart_busy,
    output logic              err_underrun,
    output logic              err_overrun,
    output logic              active
);
    localparam int         ADDR_BYTES = ADDR_W / 8;
    localparam logic [1:0] LAST_ADDR  = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] LAST_DUMMY = 2'(DUMMY_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_STAT, S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sck_prev_q, cs_prev_q, busy_prev_q;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [6:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic                   fixed_q, fixed_d, is_read_q, is_read_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             dout_q, dout_d, rdata_q, rdata_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    logic                   rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
    logic                   rd_inflight_q, rd_inflight_d, data_valid_q, data_valid_d;
    logic                   und_q, und_d, ovr_q, ovr_d;

    logic sck_s, mosi_s, cs_s, sck_rise, sck_fall, cs_rise, cs_fall, busy_fall, byte_done, can_issue;
    logic load_now, und_set, ovr_set;
    logic [7:0]        byte_val;
    logic [ADDR_W+7:0] addr_cat;

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign busy_fall = busy_prev_q & ~cart_busy;
    assign byte_val  = {rx_q, mosi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
    assign addr_cat  = {addr_q, byte_val};
    assign can_issue = !cart_busy && !rd_q && !wr_q && !cs_fall;

    // cs chain resets high so a frame cut by rst stays ignored until cs is seen low then high again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            busy_prev_q <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            busy_prev_q <= cart_busy;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        fixed_d       = fixed_q;
        is_read_d     = is_read_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        rdata_d       = rdata_q;
        rd_d          = 1'b0;
        wr_d          = 1'b0;
        rd_pend_d     = rd_pend_q;
        wr_pend_d     = wr_pend_q;
        rd_inflight_d = rd_inflight_q;
        data_valid_d  = data_valid_q;
        und_d         = und_q;
        ovr_d         = ovr_q;
        load_now      = 1'b0;
        und_set       = 1'b0;
        ovr_set       = 1'b0;

        if (sck_rise) begin
            rx_d      = byte_val[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        // No shift on the fall right after a byte load, so the new MSB is presented for the next rise.
        if (sck_fall && bit_cnt_q != 3'd0)
            tx_d = {tx_q[6:0], 1'b0};

        // A capture that completes while a newer prefetch is queued belongs to an aborted frame.
        if (rd_inflight_q && busy_fall) begin
            rd_inflight_d = 1'b0;
            if (!rd_pend_q) begin
                rdata_d      = cart_din;
                data_valid_d = 1'b1;
            end
        end
        if (rd_pend_q && can_issue) begin
            rd_d          = 1'b1;
            rd_pend_d     = 1'b0;
            rd_inflight_d = 1'b1;
        end else if (wr_pend_q && can_issue) begin
            wr_d      = 1'b1;
            wr_pend_d = 1'b0;
        end
        if (wr_q && !fixed_q)
            addr_d = addr_q + 1'b1;

        case (state_q)
            S_IDLE: if (cs_rise) begin
                state_d      = S_CMD;
                bit_cnt_d    = 3'd0;
                byte_cnt_d   = 2'd0;
                data_valid_d = 1'b0;
            end
            S_CMD: if (byte_done) begin
                fixed_d    = byte_val[0];
                byte_cnt_d = 2'd0;
                case (byte_val[7:5])
                    3'b010:  begin state_d = S_ADDR; is_read_d = 1'b1; end
                    3'b101:  begin state_d = S_ADDR; is_read_d = 1'b0; end
                    3'b000:  begin state_d = S_STAT; tx_d = {6'b0, ovr_q, und_q}; end
                    default: state_d = S_IGNORE;
                endcase
            end
            S_ADDR: if (byte_done) begin
                addr_d     = addr_cat[ADDR_W-1:0];
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == LAST_ADDR) begin
                    byte_cnt_d = 2'd0;
                    if (is_read_q) begin
                        rd_pend_d = 1'b1;
                        state_d   = (DUMMY_BYTES == 0) ? S_RDATA : S_DUMMY;
                        load_now  = (DUMMY_BYTES == 0);
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_DUMMY: if (byte_done) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == LAST_DUMMY) begin
                    state_d  = S_RDATA;
                    load_now = 1'b1;
                end
            end
            S_RDATA: if (byte_done) load_now = 1'b1;
            S_WDATA: if (byte_done) begin
                if (wr_pend_q || wr_q || cart_busy) begin
                    ovr_set = 1'b1;
                end else begin
                    dout_d    = byte_val;
                    wr_pend_d = 1'b1;
                end
            end
            S_STAT: if (byte_done) tx_d = 8'h00;
            default: ;
        endcase

        if (load_now) begin
            if (data_valid_q) begin
                tx_d         = rdata_q;
                data_valid_d = 1'b0;
                rd_pend_d    = 1'b1;
                if (!fixed_q)
                    addr_d = addr_q + 1'b1;
            end else begin
                tx_d    = 8'hFF;
                und_set = 1'b1;
            end
        end

        if (cs_fall) begin
            state_d      = S_IDLE;
            rd_pend_d    = 1'b0;
            wr_pend_d    = 1'b0;
            data_valid_d = 1'b0;
            if (state_q == S_STAT) begin
                und_d = 1'b0;
                ovr_d = 1'b0;
            end
        end
        if (und_set) und_d = 1'b1;
        if (ovr_set) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 2'd0;
            rx_q          <= 7'd0;
            tx_q          <= 8'd0;
            fixed_q       <= 1'b0;
            is_read_q     <= 1'b0;
            addr_q        <= '0;
            dout_q        <= 8'd0;
            rdata_q       <= 8'd0;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            rd_pend_q     <= 1'b0;
            wr_pend_q     <= 1'b0;
            rd_inflight_q <= 1'b0;
            data_valid_q  <= 1'b0;
            und_q         <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            fixed_q       <= fixed_d;
            is_read_q     <= is_read_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            rdata_q       <= rdata_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            rd_pend_q     <= rd_pend_d;
            wr_pend_q     <= wr_pend_d;
            rd_inflight_q <= rd_inflight_d;
            data_valid_q  <= data_valid_d;
            und_q         <= und_d;
            ovr_q         <= ovr_d;
        end
    end

    assign cart_a       = addr_q;
    assign cart_dout    = dout_q;
    assign cart_rd      = rd_q;
    assign cart_wr      = wr_q;
    assign err_underrun = und_q;
    assign err_overrun  = ovr_q;
    assign active       = (state_q != S_IDLE);
    assign spi_miso     = spi_cs && ((state_q == S_RDATA) || (state_q == S_STAT)) && tx_q[7];
endmodule
